// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg : shared types, widths and helpers for iter_divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH_DEFAULT = 64;

   // Helper operand width; the divider supports WIDTH < DIV_WIDTH_MAX.
   localparam int DIV_WIDTH_MAX = 256;

   function automatic logic [DIV_WIDTH_MAX-1:0] twos_mag(
      input logic [DIV_WIDTH_MAX-1:0] x,
      input logic                     neg
   );
      return neg ? -x : x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step : one radix-2 restoring iteration (shift, trial subtract, restore)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_step
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] dvd_next,
   output logic             q_bit
);

   logic [WIDTH:0]   w_shifted;
   logic [WIDTH+1:0] w_diff;
   logic             w_unused;

   // A kept difference is always below the divisor, so bit WIDTH is never needed.
   always_comb begin
      w_shifted = {rem, dvd[WIDTH-1]};
      w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
      q_bit     = ~w_diff[WIDTH+1];
      rem_next  = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
      dvd_next  = {dvd[WIDTH-2:0], q_bit};
      w_unused  = w_diff[WIDTH];
   end

endmodule

`default_nettype wire

// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// iter_divider : multi-cycle signed/unsigned restoring divider, valid/ready I/O
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iter_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] div,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               dbz_q, dbz_d;
   logic               out_valid_q, out_valid_d;

   logic [DIV_WIDTH_MAX-1:0] w_a_ext, w_d_ext;
   logic [DIV_WIDTH_MAX-1:0] w_a_mag_full, w_d_mag_full;
   logic [WIDTH-1:0]         w_a_mag, w_d_mag;
   logic                     w_a_neg, w_d_neg;
   logic [WIDTH-1:0]         w_rem_next, w_dvd_next;
   logic                     w_q_bit;
   logic                     w_unused;

   always_comb begin
      w_a_ext              = '0;
      w_a_ext[WIDTH-1:0]   = a;
      w_d_ext              = '0;
      w_d_ext[WIDTH-1:0]   = div;
      w_a_neg              = is_signed & a[WIDTH-1];
      w_d_neg              = is_signed & div[WIDTH-1];
      w_a_mag_full         = twos_mag(w_a_ext, w_a_neg);
      w_d_mag_full         = twos_mag(w_d_ext, w_d_neg);
      w_a_mag              = w_a_mag_full[WIDTH-1:0];
      w_d_mag              = w_d_mag_full[WIDTH-1:0];
      w_unused             = ^{w_a_mag_full[DIV_WIDTH_MAX-1:WIDTH],
                               w_d_mag_full[DIV_WIDTH_MAX-1:WIDTH], w_q_bit};
   end

   div_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .rem      (rem_q),
      .dvd      (dvd_q),
      .divisor  (dsr_q),
      .rem_next (w_rem_next),
      .dvd_next (w_dvd_next),
      .q_bit    (w_q_bit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      quo_d       = quo_q;
      r_d         = r_q;
      dbz_d       = dbz_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (div == '0) begin
                  // Result is known at once; out_valid follows one edge later.
                  quo_d   = '1;
                  r_d     = a;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  dvd_d   = w_a_mag;
                  dsr_d   = w_d_mag;
                  q_neg_d = w_a_neg ^ w_d_neg;
                  r_neg_d = w_a_neg;
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = w_rem_next;
            dvd_d = w_dvd_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               quo_d       = q_neg_q ? -w_dvd_next : w_dvd_next;
               r_d         = r_neg_q ? -w_rem_next : w_rem_next;
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quo_q       <= '0;
         r_q         <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         quo_q       <= quo_d;
         r_q         <= r_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quo         = quo_q;
   assign r           = r_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ----------------------------------------------------------------------------
// tb_iter_divider : directed scoreboard bench for iter_divider (WIDTH = 64)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_iter_divider;

   localparam int W = 64;
   localparam logic [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] C_ONES = '1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] div = '0;
   logic         is_signed = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] quo;
   logic [W-1:0] r;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   iter_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .div         (div),
      .is_signed   (is_signed),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quo         (quo),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] td, input logic ts,
                                 output logic [W-1:0] q, output logic [W-1:0] rr, output logic z);
      logic signed [W-1:0] sa, sd;
      sa = ta;
      sd = td;
      z  = 1'b0;
      if (td == '0) begin
         q  = C_ONES;
         rr = ta;
         z  = 1'b1;
      end else if (ts && ta == C_MIN && td == C_ONES) begin
         q  = C_MIN;
         rr = '0;
      end else if (ts) begin
         q  = sa / sd;
         rr = sa % sd;
      end else begin
         q  = ta / td;
         rr = ta % td;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] td, input logic ts,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int hold, input string tag);
      exp_t e, got_e;
      int   lat;
      e.q   = eq;
      e.r   = er;
      e.z   = ez;
      e.lat = ez ? 1 : W;
      sb.push_back(e);

      @(negedge clk);
      chk({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
      a         = ta;
      div       = td;
      is_signed = ts;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a         = {$urandom, $urandom};
      div       = {$urandom, $urandom};
      is_signed = 1'($urandom_range(0, 1));

      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got_e = sb.pop_front();
      chk({tag, "_latency"}, W'(lat), W'(got_e.lat));
      chk({tag, "_quo"}, quo, got_e.q);
      chk({tag, "_rem"}, r, got_e.r);
      chk({tag, "_dbz"}, W'(div_by_zero), W'(got_e.z));
      chk({tag, "_in_ready_done"}, W'(in_ready), W'(0));

      for (int k = 0; k < hold; k++) begin
         in_valid  = 1'b1;
         a         = 64'd123;
         div       = '0;
         is_signed = 1'b0;
         @(posedge clk);
         #1;
         chk({tag, "_hold_quo"}, quo, got_e.q);
         chk({tag, "_hold_rem"}, r, got_e.r);
         chk({tag, "_hold_valid"}, W'(out_valid), W'(1));
         chk({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_post_valid"}, W'(out_valid), W'(0));
      chk({tag, "_post_in_ready"}, W'(in_ready), W'(1));
   endtask

   task automatic run_model(input logic [W-1:0] ta, input logic [W-1:0] td, input logic ts,
                            input string tag);
      logic [W-1:0] q, rr;
      logic         z;
      model(ta, td, ts, q, rr, z);
      run_op(ta, td, ts, q, rr, z, 0, tag);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_quo", quo, '0);
      chk("rst_rem", r, '0);
      chk("rst_dbz", W'(div_by_zero), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;

      run_op(64'd8, 64'd2, 1'b0, 64'd4, 64'd0, 1'b0, 0, "u8_2");
      run_op(64'd9, 64'd2, 1'b0, 64'd4, 64'd1, 1'b0, 0, "u9_2");
      run_op(64'd42398284, 64'd54389, 1'b0, 64'd779, 64'd29253, 1'b0, 0, "ubig");
      run_op(64'd34224, 64'd789799, 1'b0, 64'd0, 64'd34224, 1'b0, 0, "usmall");
      run_op(-64'sd9, 64'd2, 1'b1, -64'sd4, -64'sd1, 1'b0, 0, "s_m9_2");
      run_op(64'd9, -64'sd2, 1'b1, -64'sd4, 64'd1, 1'b0, 0, "s_9_m2");
      run_op(C_MIN, C_ONES, 1'b1, C_MIN, 64'd0, 1'b0, 0, "s_min_m1");
      run_op(C_MIN, C_ONES, 1'b0, 64'd0, C_MIN, 1'b0, 0, "u_min_ones");
      run_op(64'd5, 64'd0, 1'b0, C_ONES, 64'd5, 1'b1, 0, "u5_0");
      run_op(64'd5, 64'd0, 1'b1, C_ONES, 64'd5, 1'b1, 0, "s5_0");
      run_op(64'd1000, 64'd7, 1'b0, 64'd142, 64'd6, 1'b0, 5, "bp1000_7");
      run_op(64'd77, 64'd10, 1'b0, 64'd7, 64'd7, 1'b0, 0, "after_bp");
      for (int i = 0; i < 4; i++) begin
         run_model({$urandom, $urandom}, {32'd0, $urandom} | 64'd1, 1'b0, "rand_u");
         run_model({$urandom, $urandom}, {{32{1'b1}}, $urandom}, 1'b1, "rand_s");
      end

      // Abort an operation at CALC iteration 10 with an asynchronous reset.
      @(negedge clk);
      a         = 64'd200;
      div       = 64'd3;
      is_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_calc_busy", W'(in_ready), W'(0));
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", W'(out_valid), W'(0));
      chk("arst_quo", quo, '0);
      chk("arst_rem", r, '0);
      chk("arst_dbz", W'(div_by_zero), W'(0));
      chk("arst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 0, "post_rst_100_7");

      chk("scoreboard_empty", W'(sb.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/iter_divider.md
# iter_divider

Parametrised, multi-cycle radix-2 restoring divider for the ALU, producing quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor. It runs in signed or unsigned mode per operation and retires one quotient bit per clock. It uses valid/ready handshakes on both sides so the pipeline can stall around it. Divide-by-zero and signed overflow results are defined, not left undefined.

## Interface
- WIDTH, 64: operand and result width in bits (>= 4).
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset is asynchronous and active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  divider can accept operands (high only in IDLE).
- a  in  WIDTH  dividend.
- div  in  WIDTH  divisor.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quo  out  WIDTH  quotient.
- r  out  WIDTH  remainder.
- div_by_zero  out  1  result came from a zero divisor.

## Operation
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE: in_ready=1. On in_valid, the divider latches the operands and is_signed, then branches:
  - div==0: go to DONE with quo=all-ones, r=a, div_by_zero=1.
  - otherwise: load |a| and |div| as unsigned magnitudes (|x| only when is_signed and x[WIDTH-1]); record quotient sign (a_msb XOR div_msb) and remainder sign (a_msb), both gated by is_signed; clear the partial remainder; set the iteration counter to WIDTH; go to CALC.
- CALC: each cycle, shift {rem, dvd} left by 1, trial-subtract |div|, and keep the result if it is non-negative, shifting in quotient bit 1, else 0. Decrement the counter. On the last iteration (counter==1), register the sign-corrected quo and r, set out_valid, and go to DONE.
- Signed semantics:
  - quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1 yields quo=MIN, r=0 through the normal path (magnitude 2^(WIDTH-1) is representable unsigned).
- DONE: out_valid=1. quo, r and div_by_zero hold stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE, even in the cycle of the out_ready handshake; there is no back-to-back accept.
- Inputs a, div and is_signed are ignored outside the accepting cycle.
- Reset (asserted at any time, including mid-CALC or in DONE): asynchronous return to IDLE; any in-flight operation is discarded.

## Timing
- Reset values: out_valid=0, quo=0, r=0, div_by_zero=0; in_ready=1 (decoded from IDLE).
- Normal latency: operands accepted at edge E0 make out_valid high after edge E0+WIDTH, i.e. WIDTH cycles. This holds for every non-zero divisor, independent of operand values; there is no early termination.
- Zero divisor: out_valid high after E0+1.
- Throughput: at most one operation per WIDTH+2 cycles with out_ready held high.
- All outputs are registered except in_ready, which decodes directly from the state register.

## Structure
- Shared package divider_pkg:
  - state enum (IDLE, CALC, DONE);
  - DIV_WIDTH_DEFAULT = 64;
  - function for the two's-complement magnitude.
- One natural sub-module, div_step: combinational shift and trial-subtract over WIDTH+1 bits. Inputs are rem, dvd and divisor; outputs are the next rem, the next dvd and the quotient bit. Instantiate it once.
- The counter is $clog2(WIDTH)+1 bits wide.

## Test plan
- Unsigned, WIDTH=64, out_ready=1:
  - 8/2 -> quo=4, r=0, out_valid exactly 64 cycles after accept;
  - 9/2 -> quo=4, r=1.
- Unsigned 42398284/54389 -> quo=779, r=29253. Unsigned 34224/789799 -> quo=0, r=34224.
- Signed:
  - -9/2 -> quo=-4, r=-1;
  - 9/-2 -> quo=-4, r=1;
  - MIN/-1 -> quo=MIN, r=0, div_by_zero=0.
- 5/0 in both modes -> quo=all-ones, r=5, div_by_zero=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> quo and r stable, in_ready=0, in_valid pulses ignored. Then accept; the next operation starts only after the return to IDLE.
- Reset asserted at CALC iteration 10 -> all outputs at reset values immediately, in_ready=1. A following 100/7 returns quo=14, r=2 after 64 cycles.
